// File: rtl/msrv32_buffered_store_unit_if.sv
// Data-memory write bus between the buffered store unit and data memory.
//
// Signals:
//   ms_riscv32_mp_dmdata_out    WIDTH    lane-shifted write data
//   ms_riscv32_mp_dmaddr_out    WIDTH    write address, aligned to WIDTH/8 bytes
//   ms_riscv32_mp_dmwr_mask_out WIDTH/8  byte-enable mask
//   ms_riscv32_mp_dmwr_req_out  1        write request; the above fields are valid
//   ms_riscv32_mp_dm_ack_in     1        memory accepted the presented write
//
// Modports: master = store unit side, slave = memory side.
interface msrv32_buffered_store_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   ms_riscv32_mp_dmdata_out;
  logic [WIDTH-1:0]   ms_riscv32_mp_dmaddr_out;
  logic [WIDTH/8-1:0] ms_riscv32_mp_dmwr_mask_out;
  logic               ms_riscv32_mp_dmwr_req_out;
  logic               ms_riscv32_mp_dm_ack_in;

  modport master (
    output ms_riscv32_mp_dmdata_out,
    output ms_riscv32_mp_dmaddr_out,
    output ms_riscv32_mp_dmwr_mask_out,
    output ms_riscv32_mp_dmwr_req_out,
    input  ms_riscv32_mp_dm_ack_in
  );

  modport slave (
    input  ms_riscv32_mp_dmdata_out,
    input  ms_riscv32_mp_dmaddr_out,
    input  ms_riscv32_mp_dmwr_mask_out,
    input  ms_riscv32_mp_dmwr_req_out,
    output ms_riscv32_mp_dm_ack_in
  );
endinterface

// File: rtl/msrv32_buffered_store_unit.sv
// Buffered store unit for the msrv32 core.
//
// Formats SB/SH/SW (and SD when WIDTH=64) stores into byte-lane data plus a
// byte-enable mask and queues them in a DEPTH-entry FIFO that drains to data
// memory over a req/ack handshake. Misaligned or illegal stores are dropped
// and reported with a one-cycle fault pulse.
//
// Ports:
//   ms_riscv32_mp_clk_in  clock, rising edge
//   ms_riscv32_mp_rst_in  synchronous active-high reset
//   funct3_in             store size: 00 byte, 01 half, 10 word, 11 double
//   iadder_in             effective byte address
//   rs2_in                store data, right-aligned
//   mem_wr_req_in         store request valid
//   st_ready_out          buffer not full
//   st_fault_out          previous request was misaligned/illegal (1-cycle pulse)
//   st_empty_out          buffer empty
//   st_count_out          buffer occupancy
//   dm_bus                data-memory write bus (master side)
module msrv32_buffered_store_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic [1:0]       funct3_in,
  input  logic [WIDTH-1:0] iadder_in,
  input  logic [WIDTH-1:0] rs2_in,
  input  logic             mem_wr_req_in,
  output logic             st_ready_out,
  output logic             st_fault_out,
  output logic             st_empty_out,
  output logic [CNT_W-1:0] st_count_out,
  msrv32_buffered_store_unit_if.master dm_bus
);

  localparam int NB     = WIDTH / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // ---------------------------------------------------------------------
  // Store formatting
  // ---------------------------------------------------------------------
  logic [LANE_W-1:0] lane;
  logic [LANE_W+2:0] shamt;
  logic              legal;
  logic [WIDTH-1:0]  fmt_data;
  logic [WIDTH-1:0]  fmt_addr;
  logic [NB-1:0]     fmt_mask;

  assign lane     = iadder_in[LANE_W-1:0];
  assign shamt    = {lane, 3'b000};
  assign fmt_addr = {iadder_in[WIDTH-1:LANE_W], {LANE_W{1'b0}}};

  always_comb begin
    legal    = 1'b0;
    fmt_data = '0;
    fmt_mask = '0;
    case (funct3_in)
      2'b00: begin
        legal    = 1'b1;
        fmt_data = WIDTH'(rs2_in[7:0]) << shamt;
        fmt_mask = NB'(1'b1) << lane;
      end
      2'b01: begin
        legal    = ~lane[0];
        fmt_data = WIDTH'(rs2_in[15:0]) << shamt;
        fmt_mask = NB'(2'b11) << lane;
      end
      2'b10: begin
        legal    = (lane[1:0] == 2'b00);
        fmt_data = WIDTH'(rs2_in[31:0]) << shamt;
        fmt_mask = NB'(4'hF) << lane;
      end
      default: begin
        // A doubleword only exists on the 64-bit datapath and must be
        // naturally aligned, i.e. occupy every lane.
        legal    = (WIDTH == 64) && (lane == '0);
        fmt_data = rs2_in;
        fmt_mask = '1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Store FIFO
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] addr_mem [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [NB-1:0]    mask_mem [DEPTH];

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic             fault_reg;
  logic             empty;
  logic             push;
  logic             pop;

  assign empty        = (count_reg == '0);
  // Readiness reflects the current occupancy only: a full buffer refuses a
  // store even if the head drains in the same cycle.
  assign st_ready_out = (count_reg < DEPTH_C);
  assign push         = mem_wr_req_in & st_ready_out & legal;
  assign pop          = ~empty & dm_bus.ms_riscv32_mp_dm_ack_in;

  // Entry storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (push) begin
      addr_mem[tail_reg] <= fmt_addr;
      data_mem[tail_reg] <= fmt_data;
      mask_mem[tail_reg] <= fmt_mask;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      fault_reg <= 1'b0;
    end else begin
      if (push) begin
        tail_reg <= tail_reg + PTR_W'(1);
      end
      if (pop) begin
        head_reg <= head_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      // Faults are reported whether or not the buffer had room.
      fault_reg <= mem_wr_req_in & ~legal;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: head entry straight from storage, forced to zero when empty so
  // stale entries never reach the bus. A store written this cycle is only
  // visible after the clock edge, so there is no same-cycle bypass.
  // ---------------------------------------------------------------------
  assign dm_bus.ms_riscv32_mp_dmwr_req_out  = ~empty;
  assign dm_bus.ms_riscv32_mp_dmaddr_out    = empty ? '0 : addr_mem[head_reg];
  assign dm_bus.ms_riscv32_mp_dmdata_out    = empty ? '0 : data_mem[head_reg];
  assign dm_bus.ms_riscv32_mp_dmwr_mask_out = empty ? '0 : mask_mem[head_reg];

  assign st_fault_out = fault_reg;
  assign st_empty_out = empty;
  assign st_count_out = count_reg;

endmodule

// File: tb/tb_msrv32_buffered_store_unit.sv
module tb_msrv32_buffered_store_unit;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  // 32-bit instance (a)
  logic [1:0]  f3_a = '0;
  logic [31:0] addr_a = '0, rs2_a = '0;
  logic        req_a = 1'b0;
  logic        ready_a, fault_a, empty_a;
  logic [2:0]  count_a;
  msrv32_buffered_store_unit_if #(.WIDTH(32)) bus_a ();

  msrv32_buffered_store_unit #(.WIDTH(32), .DEPTH(DEPTH)) dut_a (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .funct3_in(f3_a), .iadder_in(addr_a), .rs2_in(rs2_a), .mem_wr_req_in(req_a),
    .st_ready_out(ready_a), .st_fault_out(fault_a), .st_empty_out(empty_a),
    .st_count_out(count_a), .dm_bus(bus_a.master)
  );

  // 64-bit instance (b)
  logic [1:0]  f3_b = '0;
  logic [63:0] addr_b = '0, rs2_b = '0;
  logic        req_b = 1'b0;
  logic        ready_b, fault_b, empty_b;
  logic [2:0]  count_b;
  msrv32_buffered_store_unit_if #(.WIDTH(64)) bus_b ();

  msrv32_buffered_store_unit #(.WIDTH(64), .DEPTH(DEPTH)) dut_b (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .funct3_in(f3_b), .iadder_in(addr_b), .rs2_in(rs2_b), .mem_wr_req_in(req_b),
    .st_ready_out(ready_b), .st_fault_out(fault_b), .st_empty_out(empty_b),
    .st_count_out(count_b), .dm_bus(bus_b.master)
  );

  initial begin
    bus_a.ms_riscv32_mp_dm_ack_in = 1'b0;
    bus_b.ms_riscv32_mp_dm_ack_in = 1'b0;
  end

  // ------------------------------------------------------------------
  // Reference model: an in-order queue of formatted entries per instance.
  // ------------------------------------------------------------------
  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } entry_t;

  entry_t q_a[$];
  entry_t q_b[$];
  logic   fault_exp_a = 1'b0;
  logic   fault_exp_b = 1'b0;
  int     checks = 0;
  int     failures = 0;

  // Byte-by-byte placement: size bytes starting at lane addr mod (width/8).
  function automatic void fmt(input int width, input logic [1:0] size,
                              input logic [63:0] addr, input logic [63:0] rs2,
                              output logic legal, output entry_t e);
    int nb = width / 8;
    int sb = 1 << size;
    int lane = int'(addr % 64'(nb));
    legal  = (sb <= nb) && ((addr % 64'(sb)) == 0);
    e      = '0;
    e.addr = addr - 64'(lane);
    for (int b = 0; b < nb; b++) begin
      if (b >= lane && b < lane + sb) begin
        e.data[b*8 +: 8] = rs2[(b-lane)*8 +: 8];
        e.mask[b] = 1'b1;
      end
    end
  endfunction

  // {req, ready, empty, fault, count[3:0], addr[63:0], data[63:0], mask[7:0]}
  function automatic logic [147:0] obs_a();
    return {bus_a.ms_riscv32_mp_dmwr_req_out, ready_a, empty_a, fault_a, 4'(count_a),
            64'(bus_a.ms_riscv32_mp_dmaddr_out), 64'(bus_a.ms_riscv32_mp_dmdata_out),
            8'(bus_a.ms_riscv32_mp_dmwr_mask_out)};
  endfunction

  function automatic logic [147:0] obs_b();
    return {bus_b.ms_riscv32_mp_dmwr_req_out, ready_b, empty_b, fault_b, 4'(count_b),
            bus_b.ms_riscv32_mp_dmaddr_out, bus_b.ms_riscv32_mp_dmdata_out,
            bus_b.ms_riscv32_mp_dmwr_mask_out};
  endfunction

  function automatic logic [147:0] exp_a();
    entry_t h = '0;
    int n = q_a.size();
    if (n > 0) h = q_a[0];
    return {n > 0, n < DEPTH, n == 0, fault_exp_a, 4'(n), h.addr, h.data, h.mask};
  endfunction

  function automatic logic [147:0] exp_b();
    entry_t h = '0;
    int n = q_b.size();
    if (n > 0) h = q_b[0];
    return {n > 0, n < DEPTH, n == 0, fault_exp_b, 4'(n), h.addr, h.data, h.mask};
  endfunction

  // One clock of stimulus on instance a, with the model advanced alongside.
  task automatic cyc_a(input logic req, input logic [1:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic ack);
    logic legal;
    entry_t e;
    bit do_pop, do_push;
    req_a = req; f3_a = f3; addr_a = a; rs2_a = d;
    bus_a.ms_riscv32_mp_dm_ack_in = ack;
    fmt(32, f3, {32'b0, a}, {32'b0, d}, legal, e);
    do_pop  = ack && (q_a.size() > 0);
    do_push = req && legal && (q_a.size() < DEPTH);
    @(posedge clk); #1;
    if (rst) begin
      q_a.delete(); q_b.delete(); fault_exp_a = 1'b0; fault_exp_b = 1'b0;
    end else begin
      if (do_pop) begin
        $display("[a] write addr=%h data=%h mask=%h", q_a[0].addr[31:0], q_a[0].data[31:0], q_a[0].mask[3:0]);
        void'(q_a.pop_front());
      end
      if (do_push) begin
        $display("[a] push  addr=%h data=%h mask=%h", e.addr[31:0], e.data[31:0], e.mask[3:0]);
        q_a.push_back(e);
      end
      fault_exp_a = req && !legal;
      fault_exp_b = 1'b0;
    end
    req_a = 1'b0;
    bus_a.ms_riscv32_mp_dm_ack_in = 1'b0;
  endtask

  task automatic cyc_b(input logic req, input logic [1:0] f3, input logic [63:0] a,
                       input logic [63:0] d, input logic ack);
    logic legal;
    entry_t e;
    bit do_pop, do_push;
    req_b = req; f3_b = f3; addr_b = a; rs2_b = d;
    bus_b.ms_riscv32_mp_dm_ack_in = ack;
    fmt(64, f3, a, d, legal, e);
    do_pop  = ack && (q_b.size() > 0);
    do_push = req && legal && (q_b.size() < DEPTH);
    @(posedge clk); #1;
    if (rst) begin
      q_a.delete(); q_b.delete(); fault_exp_a = 1'b0; fault_exp_b = 1'b0;
    end else begin
      if (do_pop) begin
        $display("[b] write addr=%h data=%h mask=%h", q_b[0].addr, q_b[0].data, q_b[0].mask);
        void'(q_b.pop_front());
      end
      if (do_push) begin
        $display("[b] push  addr=%h data=%h mask=%h", e.addr, e.data, e.mask);
        q_b.push_back(e);
      end
      fault_exp_b = req && !legal;
      fault_exp_a = 1'b0;
    end
    req_b = 1'b0;
    bus_b.ms_riscv32_mp_dm_ack_in = 1'b0;
  endtask

  // ------------------------------------------------------------------
  // Scenarios
  // ------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    cyc_a(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    cyc_a(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    checks++;
    if (obs_a() !== {4'b0110, 4'd0, 136'd0}) begin
      failures++; $display("FAIL reset_a got=%h exp=%h", obs_a(), {4'b0110, 4'd0, 136'd0});
    end
    checks++;
    if (obs_b() !== {4'b0110, 4'd0, 136'd0}) begin
      failures++; $display("FAIL reset_b got=%h exp=%h", obs_b(), {4'b0110, 4'd0, 136'd0});
    end
  endtask

  task automatic test_byte();
    cyc_a(1'b1, 2'b00, 32'h1003, 32'hAABBCCDD, 1'b0);
    checks++;
    if ({bus_a.ms_riscv32_mp_dmwr_req_out, count_a, bus_a.ms_riscv32_mp_dmaddr_out,
         bus_a.ms_riscv32_mp_dmdata_out, bus_a.ms_riscv32_mp_dmwr_mask_out}
        !== {1'b1, 3'd1, 32'h1000, 32'hDD000000, 4'b1000}) begin
      failures++; $display("FAIL sb_format got=%h exp=%h", obs_a(), exp_a());
    end
    checks++;
    if (obs_a() !== exp_a()) begin
      failures++; $display("FAIL sb_model got=%h exp=%h", obs_a(), exp_a());
    end
    cyc_a(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    checks++;
    if ({bus_a.ms_riscv32_mp_dmwr_req_out, empty_a} !== 2'b01) begin
      failures++; $display("FAIL sb_drain got req/empty=%b exp=01",
                           {bus_a.ms_riscv32_mp_dmwr_req_out, empty_a});
    end
  endtask

  task automatic test_half_fault();
    cyc_a(1'b1, 2'b01, 32'h2002, 32'h1234, 1'b0);
    checks++;
    if ({bus_a.ms_riscv32_mp_dmdata_out, bus_a.ms_riscv32_mp_dmwr_mask_out}
        !== {32'h12340000, 4'b1100}) begin
      failures++; $display("FAIL sh_format got=%h exp=%h", obs_a(), exp_a());
    end
    cyc_a(1'b1, 2'b01, 32'h2001, 32'h5678, 1'b0);
    checks++;
    if ({fault_a, count_a} !== {1'b1, 3'd1}) begin
      failures++; $display("FAIL sh_misaligned got fault/count=%b exp=1001", {fault_a, count_a});
    end
    cyc_a(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    checks++;
    if ({fault_a, count_a} !== {1'b0, 3'd1}) begin
      failures++; $display("FAIL fault_pulse got fault/count=%b exp=0001", {fault_a, count_a});
    end
    cyc_a(1'b1, 2'b11, 32'h2000, 32'h9999, 1'b0);
    checks++;
    if ({fault_a, count_a} !== {1'b1, 3'd1}) begin
      failures++; $display("FAIL sd_on_32 got fault/count=%b exp=1001", {fault_a, count_a});
    end
    cyc_a(1'b1, 2'b10, 32'h2006, 32'h9999, 1'b1);
    checks++;
    if ({fault_a, count_a, empty_a} !== {1'b1, 3'd0, 1'b1}) begin
      failures++; $display("FAIL sw_misaligned got fault/count/empty=%b exp=10001",
                           {fault_a, count_a, empty_a});
    end
    checks++;
    if (obs_a() !== exp_a()) begin
      failures++; $display("FAIL fault_model got=%h exp=%h", obs_a(), exp_a());
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) cyc_a(1'b1, 2'b10, 32'h10 + 32'(4*i), 32'(i+1), 1'b0);
    checks++;
    if ({ready_a, count_a} !== {1'b0, 3'd4}) begin
      failures++; $display("FAIL fill_full got ready/count=%b exp=0100", {ready_a, count_a});
    end
    cyc_a(1'b1, 2'b10, 32'h20, 32'h5, 1'b0);
    checks++;
    if ({count_a, fault_a, ready_a} !== {3'd4, 1'b0, 1'b0}) begin
      failures++; $display("FAIL fifth_ignored got count/fault/ready=%b exp=10000",
                           {count_a, fault_a, ready_a});
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus_a.ms_riscv32_mp_dmwr_req_out, bus_a.ms_riscv32_mp_dmaddr_out,
           bus_a.ms_riscv32_mp_dmdata_out, bus_a.ms_riscv32_mp_dmwr_mask_out}
          !== {1'b1, 32'h10 + 32'(4*i), 32'(i+1), 4'hF}) begin
        failures++; $display("FAIL drain_order[%0d] got=%h exp=%h", i, obs_a(), exp_a());
      end
      cyc_a(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    end
    checks++;
    if ({bus_a.ms_riscv32_mp_dmwr_req_out, empty_a} !== 2'b01) begin
      failures++; $display("FAIL fill_empty got req/empty=%b exp=01",
                           {bus_a.ms_riscv32_mp_dmwr_req_out, empty_a});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3];
    logic [31:0] exp_ad [3];
    exp_d  = '{32'h13, 32'h14, 32'h55};
    exp_ad = '{32'h38, 32'h3C, 32'h40};
    for (int i = 0; i < 4; i++) cyc_a(1'b1, 2'b10, 32'h30 + 32'(4*i), 32'h11 + 32'(i), 1'b0);
    // Full: the held request is refused while the head drains.
    cyc_a(1'b1, 2'b10, 32'h40, 32'h55, 1'b1);
    checks++;
    if ({count_a, ready_a} !== {3'd3, 1'b1}) begin
      failures++; $display("FAIL full_push_ack got count/ready=%b exp=0111", {count_a, ready_a});
    end
    // Not full: push and pop together leave the count unchanged.
    cyc_a(1'b1, 2'b10, 32'h40, 32'h55, 1'b1);
    checks++;
    if (count_a !== 3'd3) begin
      failures++; $display("FAIL push_pop_count got=%0d exp=3", count_a);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus_a.ms_riscv32_mp_dmaddr_out, bus_a.ms_riscv32_mp_dmdata_out}
          !== {exp_ad[i], exp_d[i]}) begin
        failures++; $display("FAIL b2b_order[%0d] got=%h exp=%h", i, obs_a(), exp_a());
      end
      cyc_a(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    end
    checks++;
    if (empty_a !== 1'b1) begin
      failures++; $display("FAIL b2b_empty got=%b exp=1", empty_a);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cyc_a(1'b1, 2'b10, 32'h50 + 32'(4*i), 32'hA0 + 32'(i), 1'b0);
    rst = 1'b1;
    cyc_a(1'b1, 2'b10, 32'h5C, 32'hA3, 1'b1);
    rst = 1'b0;
    checks++;
    if (obs_a() !== {4'b0110, 4'd0, 136'd0}) begin
      failures++; $display("FAIL reset_mid got=%h exp=%h", obs_a(), {4'b0110, 4'd0, 136'd0});
    end
    cyc_a(1'b1, 2'b10, 32'h40, 32'hDEADBEEF, 1'b0);
    checks++;
    if ({bus_a.ms_riscv32_mp_dmwr_req_out, bus_a.ms_riscv32_mp_dmaddr_out,
         bus_a.ms_riscv32_mp_dmdata_out, bus_a.ms_riscv32_mp_dmwr_mask_out}
        !== {1'b1, 32'h40, 32'hDEADBEEF, 4'hF}) begin
      failures++; $display("FAIL post_reset_sw got=%h exp=%h", obs_a(), exp_a());
    end
    cyc_a(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    checks++;
    if (empty_a !== 1'b1) begin
      failures++; $display("FAIL post_reset_drain got=%b exp=1", empty_a);
    end
  endtask

  task automatic test_wide64();
    cyc_b(1'b1, 2'b11, 64'h08, 64'h0123456789ABCDEF, 1'b0);
    checks++;
    if ({bus_b.ms_riscv32_mp_dmwr_mask_out, bus_b.ms_riscv32_mp_dmaddr_out,
         bus_b.ms_riscv32_mp_dmdata_out} !== {8'hFF, 64'h08, 64'h0123456789ABCDEF}) begin
      failures++; $display("FAIL sd_format got=%h exp=%h", obs_b(), exp_b());
    end
    cyc_b(1'b1, 2'b10, 64'h0C, 64'h11112222CAFEF00D, 1'b0);
    cyc_b(1'b1, 2'b11, 64'h04, 64'h5555, 1'b1);
    checks++;
    if ({fault_b, count_b, bus_b.ms_riscv32_mp_dmaddr_out, bus_b.ms_riscv32_mp_dmdata_out,
         bus_b.ms_riscv32_mp_dmwr_mask_out}
        !== {1'b1, 3'd1, 64'h08, 64'hCAFEF00D00000000, 8'hF0}) begin
      failures++; $display("FAIL sw64_sd_fault got=%h exp=%h", obs_b(), exp_b());
    end
    cyc_b(1'b1, 2'b01, 64'h0E, 64'hBEEF, 1'b1);
    checks++;
    if ({fault_b, bus_b.ms_riscv32_mp_dmdata_out, bus_b.ms_riscv32_mp_dmwr_mask_out}
        !== {1'b0, 64'hBEEF000000000000, 8'hC0}) begin
      failures++; $display("FAIL sh64_format got=%h exp=%h", obs_b(), exp_b());
    end
    cyc_b(1'b0, 2'b00, 64'h0, 64'h0, 1'b1);
    checks++;
    if (obs_b() !== exp_b()) begin
      failures++; $display("FAIL wide64_model got=%h exp=%h", obs_b(), exp_b());
    end
  endtask

  task automatic test_random32();
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(99) < 2);
      cyc_a($urandom_range(99) < 60, 2'($urandom_range(3)), $urandom & 32'h0000_0FFF,
            $urandom, $urandom_range(99) < 45);
      rst = 1'b0;
      checks++;
      if (obs_a() !== exp_a()) begin
        failures++; $display("FAIL rand32[%0d] got=%h exp=%h", i, obs_a(), exp_a());
      end
    end
  endtask

  task automatic test_random64();
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(99) < 2);
      cyc_b($urandom_range(99) < 60, 2'($urandom_range(3)), {32'h0, $urandom & 32'h0000_0FFF},
            {$urandom, $urandom}, $urandom_range(99) < 45);
      rst = 1'b0;
      checks++;
      if (obs_b() !== exp_b()) begin
        failures++; $display("FAIL rand64[%0d] got=%h exp=%h", i, obs_b(), exp_b());
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_half_fault();
    test_fill_drain();
    test_back_to_back();
    test_reset_mid();
    test_wide64();
    test_random32();
    test_random64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
